// File: rtl/serial_alu_ctrl.sv
// Serial ALU controller: sequences an external 1-bit ALU slice over WIDTH
// cycles, one bit per cycle. SLT runs MSB first, all other ops LSB first.
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    // requester side
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    // bit-slice side
    output logic             slice_a,
    output logic             slice_b,
    output logic [2:0]       slice_s,
    output logic             slice_carry_in,
    output logic             slice_slt_kin,
    output logic             slice_slt_ans_in,
    output logic             slice_first,
    input  logic             slice_out,
    input  logic             slice_carryout,
    input  logic             slice_slt_kout,
    input  logic             slice_slt_ans_out
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ILL = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_k;
    logic             r_ans;
    logic [WIDTH-1:0] r_result;
    logic             r_carryout;

    logic             w_is_slt;
    logic             w_last;
    logic [IW-1:0]    w_bit;

    assign w_is_slt = (r_op == OP_SLT);
    assign w_last   = (r_idx == LAST_IDX);
    // SLT walks from the MSB down so the slice can resolve the sign bit first
    assign w_bit    = w_is_slt ? (LAST_IDX - r_idx) : r_idx;

    assign result   = r_result;
    assign carryout = r_carryout;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (op == OP_ILL) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, bit counter, slice feedback and result assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_k        <= 1'b1;
            r_ans      <= 1'b0;
            r_result   <= '0;
            r_carryout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx      <= '0;
                        r_carry    <= 1'b0;
                        r_k        <= 1'b1;
                        r_ans      <= 1'b0;
                        r_result   <= '0;
                        r_carryout <= 1'b0;
                        if (op != OP_ILL) begin
                            r_a  <= a;
                            r_b  <= b;
                            r_op <= op;
                        end
                    end
                end
                S_RUN: begin
                    r_idx   <= w_last ? '0 : r_idx + 1'b1;
                    r_carry <= slice_carryout;
                    r_k     <= slice_slt_kout;
                    r_ans   <= slice_slt_ans_out;
                    if (w_is_slt) begin
                        // only the final comparison answer matters for SLT
                        if (w_last) begin
                            r_result <= {{(WIDTH-1){1'b0}}, slice_slt_ans_out};
                        end
                    end else begin
                        r_result[w_bit] <= slice_out;
                    end
                    if (w_last) begin
                        r_carryout <= (r_op == OP_ADD) ? slice_carryout : 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Slice drive: live only during RUN, SLT-specific lines only for SLT
    always_comb begin
        slice_a          = 1'b0;
        slice_b          = 1'b0;
        slice_s          = 3'b000;
        slice_carry_in   = 1'b0;
        slice_slt_kin    = 1'b0;
        slice_slt_ans_in = 1'b0;
        slice_first      = 1'b0;
        if (r_state == S_RUN) begin
            slice_a = r_a[w_bit];
            slice_b = r_b[w_bit];
            slice_s = r_op;
            if (r_op == OP_ADD) begin
                slice_carry_in = r_carry;
            end
            if (w_is_slt) begin
                slice_slt_kin    = r_k;
                slice_slt_ans_in = r_ans;
                slice_first      = (r_idx == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Bench for serial_alu_ctrl paired with a behavioural 1-bit ALU slice.
module tb_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carryout;
    logic         slice_a;
    logic         slice_b;
    logic [2:0]   slice_s;
    logic         slice_carry_in;
    logic         slice_slt_kin;
    logic         slice_slt_ans_in;
    logic         slice_first;
    logic         slice_out;
    logic         slice_carryout;
    logic         slice_slt_kout;
    logic         slice_slt_ans_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic         cy;
        int           lat;
        int           busy_cyc;
        bit           slt;
    } exp_t;

    exp_t sb[$];

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .a                 (a),
        .b                 (b),
        .op                (op),
        .busy              (busy),
        .done              (done),
        .result            (result),
        .carryout          (carryout),
        .slice_a           (slice_a),
        .slice_b           (slice_b),
        .slice_s           (slice_s),
        .slice_carry_in    (slice_carry_in),
        .slice_slt_kin     (slice_slt_kin),
        .slice_slt_ans_in  (slice_slt_ans_in),
        .slice_first       (slice_first),
        .slice_out         (slice_out),
        .slice_carryout    (slice_carryout),
        .slice_slt_kout    (slice_slt_kout),
        .slice_slt_ans_out (slice_slt_ans_out)
    );

    always #5 clk = ~clk;

    // Behavioural slice: signed SLT resolved MSB first, sign bit on slice_first
    always_comb begin
        slice_out         = 1'b0;
        slice_carryout    = 1'b0;
        slice_slt_kout    = 1'b0;
        slice_slt_ans_out = slice_slt_ans_in;
        case (slice_s)
            3'b000: begin
                slice_out      = slice_a ^ slice_b ^ slice_carry_in;
                slice_carryout = (slice_a & slice_b) | (slice_carry_in & (slice_a ^ slice_b));
            end
            3'b010: slice_out = slice_a ^ slice_b;
            3'b100: slice_out = slice_a & slice_b;
            3'b101: slice_out = ~(slice_a & slice_b);
            3'b110: slice_out = ~(slice_a | slice_b);
            3'b111: slice_out = slice_a | slice_b;
            3'b011: begin
                if (slice_slt_kin && (slice_a != slice_b)) begin
                    slice_slt_kout    = 1'b0;
                    slice_slt_ans_out = slice_first ? (slice_a & ~slice_b) : (~slice_a & slice_b);
                end else begin
                    slice_slt_kout = slice_slt_kin;
                end
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and compare the completion against the scoreboard.
    // disturb=1 re-pulses start and changes operands in the middle of RUN.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [W-1:0] res, input logic cy,
                          input bit disturb);
        exp_t e;
        exp_t got;
        int n = 0;
        int nbusy = 0;
        int nfirst = 0;
        int first_at1 = 0;
        int extra = 0;
        bit seen = 0;
        e.tag = tag;
        e.res = res;
        e.cy = cy;
        e.lat = (o == 3'b001) ? 1 : W + 1;
        e.busy_cyc = (o == 3'b001) ? 0 : W;
        e.slt = (o == 3'b011);
        sb.push_back(e);
        start = 1'b1;
        a = va;
        b = vb;
        op = o;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) start = 1'b0;
            if (disturb && n == 3) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'hFF;
            end
            if (disturb && n == 4) start = 1'b0;
            if (busy) nbusy++;
            if (slice_first) begin
                nfirst++;
                if (n == 1) first_at1 = 1;
            end
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        if (seen && sb.size() > 0) begin
            got = sb.pop_front();
            chk({got.tag, "_result"}, int'(result), int'(got.res));
            chk({got.tag, "_carryout"}, int'(carryout), int'(got.cy));
            chk({got.tag, "_latency"}, n, got.lat);
            chk({got.tag, "_busy_cycles"}, nbusy, got.busy_cyc);
            if (got.slt) begin
                chk({got.tag, "_first_count"}, nfirst, 1);
                chk({got.tag, "_first_at_idx0"}, first_at1, 1);
            end
        end else if (!seen) begin
            void'(sb.pop_front());
        end
        // done is a single pulse and no further operation starts on its own
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        chk({tag, "_no_extra_done"}, extra, 0);
        chk({tag, "_slice_idle"}, int'({slice_a, slice_b, slice_s, slice_carry_in,
                                        slice_slt_kin, slice_slt_ans_in, slice_first}), 0);
    endtask

    initial begin
        int extra;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        op = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_carryout", int'(carryout), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("add_ff_01",  3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 0);
        run_op("xor_a5_0f",  3'b010, 8'hA5, 8'h0F, 8'hAA, 1'b0, 0);
        run_op("nand_f0_3c", 3'b101, 8'hF0, 8'h3C, 8'hCF, 1'b0, 0);
        run_op("or_81_18",   3'b111, 8'h81, 8'h18, 8'h99, 1'b0, 0);
        run_op("slt_12_34",  3'b011, 8'h12, 8'h34, 8'h01, 1'b0, 0);
        run_op("slt_34_34",  3'b011, 8'h34, 8'h34, 8'h00, 1'b0, 0);
        run_op("slt_35_34",  3'b011, 8'h35, 8'h34, 8'h00, 1'b0, 0);
        run_op("slt_neg",    3'b011, 8'h80, 8'h01, 8'h01, 1'b0, 0);
        run_op("and_3c_f0",  3'b100, 8'h3C, 8'hF0, 8'h30, 1'b0, 0);
        run_op("nor_81_18",  3'b110, 8'h81, 8'h18, 8'h66, 1'b0, 0);
        run_op("add_disturb", 3'b000, 8'h0F, 8'h01, 8'h10, 1'b0, 1);
        run_op("illegal_op", 3'b001, 8'h55, 8'h66, 8'h00, 1'b0, 0);

        // Abort an ADD in its 4th RUN cycle
        start = 1'b1;
        a = 8'h7F;
        b = 8'h01;
        op = 3'b000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_in_run", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_done", int'(done), 0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        chk("abort_no_done", extra, 0);
        run_op("add_after_abort", 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
